// File: rtl/enigma_scheduler.sv
// Arbitrates IR and local letter requests onto the shared Enigma core, one letter in flight,
// and sequences rotor reconfiguration between letters.
module enigma_scheduler #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ir_valid_in,
   input  logic [4:0]  ir_letter_in,
   input  logic        key_valid_in,
   input  logic [4:0]  key_letter_in,
   input  logic        cfg_valid_in,
   input  logic [8:0]  rotor_select_in,
   input  logic [14:0] rotor_initial_in,
   input  logic        enc_ready_in,
   output logic        enc_valid_out,
   output logic [4:0]  enc_letter_out,
   output logic        enc_rotor_valid_out,
   output logic [8:0]  enc_rotor_select_out,
   output logic [14:0] enc_rotor_initial_out,
   input  logic        enc_valid_in,
   input  logic [4:0]  enc_letter_in,
   output logic        disp_valid_out,
   output logic [4:0]  disp_letter_out,
   output logic        disp_src_out,
   output logic [7:0]  drop_count_out,
   output logic        timeout_out,
   output logic        busy_out
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Result must land within TIMEOUT_CYCLES-1 WAIT cycles so the pulse sits TIMEOUT_CYCLES
   // cycles after the ISSUE cycle.
   localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [AW:0]   FifoFull = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StCfg     = 3'd1;
   localparam logic [2:0] StCfgWait = 3'd2;
   localparam logic [2:0] StIssue   = 3'd3;
   localparam logic [2:0] StWait    = 3'd4;

   logic [2:0]    state_q, state_d;

   logic [4:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fifo_cnt_q;
   logic          fifo_empty, fifo_full;

   logic          key_full_q;
   logic [4:0]    key_letter_q;

   logic          cfg_pend_q;
   logic [8:0]    cfg_sel_q;
   logic [14:0]   cfg_init_q;

   logic          rr_q;
   logic          src_q;
   logic [4:0]    enc_letter_q;
   logic [8:0]    rot_sel_q;
   logic [14:0]   rot_init_q;
   logic          disp_valid_q;
   logic [4:0]    disp_letter_q;
   logic          disp_src_q;
   logic [7:0]    drop_q;
   logic          timeout_q;
   logic [TW-1:0] tmo_cnt_q;

   logic          ir_pend, key_pend;
   logic          grant, grant_src;
   logic [4:0]    grant_letter;
   logic          pop_ir, pop_key;
   logic          ir_ok, ir_push, ir_drop;
   logic          key_ok, key_load, key_drop;
   logic [1:0]    drop_inc;
   logic [8:0]    drop_sum;
   logic          result_hit, tmo_hit;

   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == FifoFull);

   assign ir_pend  = !fifo_empty;
   assign key_pend = key_full_q;

   // rr_q names the source preferred when both are pending (0 = IR).
   assign grant        = (state_q == StIdle) && !cfg_pend_q && enc_ready_in && (ir_pend || key_pend);
   assign grant_src    = (ir_pend && key_pend) ? rr_q : key_pend;
   assign grant_letter = grant_src ? key_letter_q : fifo_mem[rd_ptr_q];
   assign pop_ir       = grant && !grant_src;
   assign pop_key      = grant && grant_src;

   // A pop in the same cycle frees the slot before the push lands.
   assign ir_ok    = ir_valid_in && (ir_letter_in <= 5'd25);
   assign ir_push  = ir_ok && (!fifo_full || pop_ir);
   assign ir_drop  = ir_valid_in && !ir_push;
   assign key_ok   = key_valid_in && (key_letter_in <= 5'd25);
   assign key_load = key_ok && (!key_full_q || pop_key);
   assign key_drop = key_valid_in && !key_load;

   assign drop_inc = {1'b0, ir_drop} + {1'b0, key_drop};
   assign drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};

   assign result_hit = (state_q == StWait) && enc_valid_in;
   assign tmo_hit    = (state_q == StWait) && !enc_valid_in && (tmo_cnt_q == TmoLast);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cfg_pend_q) begin
               state_d = StCfg;
            end else if (grant) begin
               state_d = StIssue;
            end
         end
         StCfg:     state_d = StCfgWait;
         StCfgWait: if (enc_ready_in) state_d = StIdle;
         StIssue:   state_d = StWait;
         StWait:    if (result_hit || tmo_hit) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (ir_push) begin
         fifo_mem[wr_ptr_q] <= ir_letter_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         key_full_q <= 1'b0;
         key_letter_q <= '0;
         cfg_pend_q <= 1'b0;
         cfg_sel_q  <= '0;
         cfg_init_q <= '0;
         rr_q       <= 1'b0;
         src_q      <= 1'b0;
         drop_q     <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q <= state_d;

         if (ir_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ir)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (ir_push && !pop_ir) begin
            fifo_cnt_q <= fifo_cnt_q + 1'b1;
         end else if (!ir_push && pop_ir) begin
            fifo_cnt_q <= fifo_cnt_q - 1'b1;
         end

         if (key_load) begin
            key_full_q   <= 1'b1;
            key_letter_q <= key_letter_in;
         end else if (pop_key) begin
            key_full_q <= 1'b0;
         end

         // A request arriving in the CFG cycle itself stays pending.
         if (cfg_valid_in) begin
            cfg_pend_q <= 1'b1;
            cfg_sel_q  <= rotor_select_in;
            cfg_init_q <= rotor_initial_in;
         end else if (state_q == StCfg) begin
            cfg_pend_q <= 1'b0;
         end

         if (grant) begin
            rr_q  <= !grant_src;
            src_q <= grant_src;
         end

         drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

         if (state_q == StIssue) begin
            tmo_cnt_q <= '0;
         end else if (state_q == StWait) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         enc_letter_q  <= '0;
         rot_sel_q     <= '0;
         rot_init_q    <= '0;
         disp_valid_q  <= 1'b0;
         disp_letter_q <= '0;
         disp_src_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         if (grant) begin
            enc_letter_q <= grant_letter;
         end
         if ((state_q == StIdle) && cfg_pend_q) begin
            rot_sel_q  <= cfg_sel_q;
            rot_init_q <= cfg_init_q;
         end
         disp_valid_q <= result_hit;
         if (result_hit) begin
            disp_letter_q <= enc_letter_in;
            disp_src_q    <= src_q;
         end
         timeout_q <= tmo_hit;
      end
   end

   assign enc_valid_out         = (state_q == StIssue);
   assign enc_letter_out        = enc_letter_q;
   assign enc_rotor_valid_out   = (state_q == StCfg);
   assign enc_rotor_select_out  = rot_sel_q;
   assign enc_rotor_initial_out = rot_init_q;
   assign disp_valid_out        = disp_valid_q;
   assign disp_letter_out       = disp_letter_q;
   assign disp_src_out          = disp_src_q;
   assign drop_count_out        = drop_q;
   assign timeout_out           = timeout_q;
   assign busy_out              = (state_q != StIdle);

endmodule

// File: tb/tb_enigma_scheduler.sv
// Scoreboard bench for enigma_scheduler: a bench-side core answers each issued letter and
// the expected display traffic is queued when stimulus is driven.
module tb_enigma_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        ir_valid_in, key_valid_in, cfg_valid_in, enc_ready_in, enc_valid_in;
   logic [4:0]  ir_letter_in, key_letter_in, enc_letter_in;
   logic [8:0]  rotor_select_in;
   logic [14:0] rotor_initial_in;
   logic        enc_valid_out, enc_rotor_valid_out, disp_valid_out, disp_src_out;
   logic        timeout_out, busy_out;
   logic [4:0]  enc_letter_out, disp_letter_out;
   logic [8:0]  enc_rotor_select_out;
   logic [14:0] enc_rotor_initial_out;
   logic [7:0]  drop_count_out;
   logic [47:0] all_outs;

   typedef struct {
      logic [4:0] letter;
      logic [4:0] result;
      logic       src;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk_in = ~clk_in;

   enigma_scheduler #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .ir_valid_in(ir_valid_in), .ir_letter_in(ir_letter_in),
      .key_valid_in(key_valid_in), .key_letter_in(key_letter_in),
      .cfg_valid_in(cfg_valid_in), .rotor_select_in(rotor_select_in),
      .rotor_initial_in(rotor_initial_in), .enc_ready_in(enc_ready_in),
      .enc_valid_out(enc_valid_out), .enc_letter_out(enc_letter_out),
      .enc_rotor_valid_out(enc_rotor_valid_out), .enc_rotor_select_out(enc_rotor_select_out),
      .enc_rotor_initial_out(enc_rotor_initial_out), .enc_valid_in(enc_valid_in),
      .enc_letter_in(enc_letter_in), .disp_valid_out(disp_valid_out),
      .disp_letter_out(disp_letter_out), .disp_src_out(disp_src_out),
      .drop_count_out(drop_count_out), .timeout_out(timeout_out), .busy_out(busy_out)
   );

   assign all_outs = {enc_valid_out, enc_letter_out, enc_rotor_valid_out, enc_rotor_select_out,
                      enc_rotor_initial_out, disp_valid_out, disp_letter_out, disp_src_out,
                      drop_count_out, timeout_out, busy_out};

   function automatic logic [4:0] core_fn(input logic [4:0] x);
      return 5'((int'(x) * 7 + 3) % 26);
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_exp(input logic [4:0] l, input logic s);
      exp_t e;
      e.letter = l;
      e.result = core_fn(l);
      e.src    = s;
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      rst_in = 1'b0;
      ir_valid_in = 0; key_valid_in = 0; cfg_valid_in = 0; enc_ready_in = 0; enc_valid_in = 0;
      ir_letter_in = 0; key_letter_in = 0; enc_letter_in = 0;
      rotor_select_in = 0; rotor_initial_in = 0;
      step();
      step();
      rst_in = 1'b1;
      step();
      sb.delete();
   endtask

   task automatic wait_issue(output bit got, output logic [4:0] l);
      got = 0;
      l   = '0;
      for (int i = 0; i < 100; i++) begin
         if (enc_valid_out) begin
            got = 1;
            l   = enc_letter_out;
            return;
         end
         step();
      end
   endtask

   // Core answers two cycles after the issue cycle; returns the display outputs one cycle later.
   task automatic answer(input logic [4:0] res, output bit shown, output logic [4:0] dl,
                         output logic ds);
      step();
      step();
      enc_valid_in  = 1'b1;
      enc_letter_in = res;
      step();
      enc_valid_in = 1'b0;
      shown = disp_valid_out;
      dl    = disp_letter_out;
      ds    = disp_src_out;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (all_outs !== 48'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", all_outs);
      end
   endtask

   task automatic test_single();
      bit quiet;
      apply_reset();
      enc_ready_in = 1;
      ir_valid_in = 1; ir_letter_in = 7;
      step();
      ir_valid_in = 0;
      checks++;
      if (enc_valid_out !== 1'b0) begin
         errors++; $display("FAIL single_c1_valid: got %b want 0", enc_valid_out);
      end
      step();
      checks++;
      if (enc_valid_out !== 1'b1 || enc_letter_out !== 5'd7) begin
         errors++;
         $display("FAIL single_c2_issue: got v=%b l=%0d want v=1 l=7", enc_valid_out, enc_letter_out);
      end
      checks++;
      if (busy_out !== 1'b1) begin
         errors++; $display("FAIL single_busy: got %b want 1", busy_out);
      end
      quiet = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (disp_valid_out !== 1'b0 || enc_valid_out !== 1'b0) quiet = 0;
      end
      checks++;
      if (!quiet) begin
         errors++; $display("FAIL single_quiet_wait: got strobe want none");
      end
      enc_valid_in = 1; enc_letter_in = 19;
      step();
      enc_valid_in = 0;
      checks++;
      if (disp_valid_out !== 1'b1 || disp_letter_out !== 5'd19 || disp_src_out !== 1'b0) begin
         errors++;
         $display("FAIL single_disp: got v=%b l=%0d s=%b want v=1 l=19 s=0",
                  disp_valid_out, disp_letter_out, disp_src_out);
      end
      checks++;
      if (busy_out !== 1'b0) begin
         errors++; $display("FAIL single_busy_fall: got %b want 0", busy_out);
      end
      step();
      checks++;
      if (disp_valid_out !== 1'b0 || disp_letter_out !== 5'd19) begin
         errors++;
         $display("FAIL single_hold: got v=%b l=%0d want v=0 l=19", disp_valid_out, disp_letter_out);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bit got, shown;
      logic [4:0] l, dl;
      logic ds;
      apply_reset();
      enc_ready_in = 1;
      ir_valid_in = 1; ir_letter_in = 3; key_valid_in = 1; key_letter_in = 4;
      push_exp(3, 0); push_exp(4, 1);
      step();
      ir_valid_in = 0; key_valid_in = 0;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            enc_ready_in = 0;
            ir_valid_in = 1; ir_letter_in = 1; key_valid_in = 1; key_letter_in = 9;
            step();
            key_valid_in = 0; ir_letter_in = 2;
            step();
            ir_valid_in = 0;
            push_exp(1, 0); push_exp(9, 1); push_exp(2, 0);
            enc_ready_in = 1;
         end
         while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_issue(got, l);
            checks++;
            if (!got || l !== e.letter) begin
               errors++; $display("FAIL rr_issue: got %0d (seen=%0d) want %0d", l, got, e.letter);
            end
            answer(e.result, shown, dl, ds);
            checks++;
            if (!shown || dl !== e.result || ds !== e.src) begin
               errors++;
               $display("FAIL rr_disp: got v=%0d l=%0d s=%b want v=1 l=%0d s=%b",
                        shown, dl, ds, e.result, e.src);
            end
         end
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      bit got, shown, stray;
      logic [4:0] l, dl;
      logic ds;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         ir_valid_in = 1; ir_letter_in = 5'(i);
         step();
      end
      ir_valid_in = 0;
      checks++;
      if (drop_count_out !== 8'd2 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drop2: got drops=%0d busy=%b want 2 0", drop_count_out, busy_out);
      end
      key_valid_in = 1; key_letter_in = 30;
      step();
      key_valid_in = 0;
      checks++;
      if (drop_count_out !== 8'd3) begin
         errors++; $display("FAIL ovf_bad_key: got %0d want 3", drop_count_out);
      end
      for (int i = 0; i < 8; i++) push_exp(5'(i), 0);
      // Grant pops the full FIFO in the same cycle this push arrives.
      enc_ready_in = 1; ir_valid_in = 1; ir_letter_in = 20;
      push_exp(20, 0);
      step();
      ir_valid_in = 0;
      checks++;
      if (drop_count_out !== 8'd3) begin
         errors++; $display("FAIL ovf_full_pushpop: got %0d want 3", drop_count_out);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         wait_issue(got, l);
         checks++;
         if (!got || l !== e.letter) begin
            errors++; $display("FAIL ovf_issue: got %0d (seen=%0d) want %0d", l, got, e.letter);
         end
         answer(e.result, shown, dl, ds);
         checks++;
         if (!shown || dl !== e.result || ds !== e.src) begin
            errors++;
            $display("FAIL ovf_disp: got v=%0d l=%0d s=%b want v=1 l=%0d s=%b",
                     shown, dl, ds, e.result, e.src);
         end
      end
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (enc_valid_out) stray = 1;
      end
      checks++;
      if (stray) begin
         errors++; $display("FAIL ovf_no_extra: got issue want none");
      end
      for (int i = 0; i < 260; i++) begin
         key_valid_in = 1; key_letter_in = 31;
         step();
      end
      key_valid_in = 0;
      checks++;
      if (drop_count_out !== 8'd255) begin
         errors++; $display("FAIL drop_saturate: got %0d want 255", drop_count_out);
      end
   endtask

   task automatic test_cfg();
      bit got, shown, early;
      logic [4:0] l, dl;
      logic ds;
      apply_reset();
      enc_ready_in = 1;
      ir_valid_in = 1; ir_letter_in = 5;
      step();
      ir_letter_in = 6;
      step();
      ir_valid_in = 0;
      wait_issue(got, l);
      checks++;
      if (!got || l !== 5'd5) begin
         errors++; $display("FAIL cfg_first_issue: got %0d want 5", l);
      end
      step();
      early = 0;
      cfg_valid_in = 1; rotor_select_in = 9'h0A5; rotor_initial_in = 15'h1234;
      step();
      if (enc_rotor_valid_out) early = 1;
      rotor_select_in = 9'h15A; rotor_initial_in = 15'h4321;
      step();
      if (enc_rotor_valid_out) early = 1;
      cfg_valid_in = 0;
      enc_valid_in = 1; enc_letter_in = core_fn(5);
      step();
      enc_valid_in = 0;
      if (enc_rotor_valid_out) early = 1;
      checks++;
      if (early || disp_valid_out !== 1'b1 || disp_letter_out !== core_fn(5)) begin
         errors++;
         $display("FAIL cfg_after_disp: got early=%0d disp=%b l=%0d want early=0 disp=1 l=%0d",
                  early, disp_valid_out, disp_letter_out, core_fn(5));
      end
      step();
      checks++;
      if (enc_rotor_valid_out !== 1'b1 || enc_rotor_select_out !== 9'h15A ||
          enc_rotor_initial_out !== 15'h4321 || enc_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL cfg_strobe: got v=%b sel=%h init=%h issue=%b want 1 15a 4321 0",
                  enc_rotor_valid_out, enc_rotor_select_out, enc_rotor_initial_out, enc_valid_out);
      end
      step();
      checks++;
      if (enc_rotor_valid_out !== 1'b0 || enc_rotor_select_out !== 9'h15A) begin
         errors++;
         $display("FAIL cfg_one_cycle: got v=%b sel=%h want 0 15a",
                  enc_rotor_valid_out, enc_rotor_select_out);
      end
      wait_issue(got, l);
      checks++;
      if (!got || l !== 5'd6) begin
         errors++; $display("FAIL cfg_next_issue: got %0d want 6", l);
      end
      answer(core_fn(6), shown, dl, ds);
      checks++;
      if (!shown || dl !== core_fn(6) || ds !== 1'b0) begin
         errors++; $display("FAIL cfg_next_disp: got v=%0d l=%0d want v=1 l=%0d", shown, dl, core_fn(6));
      end
   endtask

   task automatic test_timeout();
      bit got, shown, seen_disp;
      logic [4:0] l, dl;
      logic ds;
      int first;
      apply_reset();
      enc_ready_in = 1;
      ir_valid_in = 1; ir_letter_in = 11;
      step();
      ir_letter_in = 12;
      step();
      ir_valid_in = 0;
      wait_issue(got, l);
      checks++;
      if (!got || l !== 5'd11) begin
         errors++; $display("FAIL tmo_issue: got %0d want 11", l);
      end
      first = -1;
      seen_disp = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (disp_valid_out) seen_disp = 1;
         if (timeout_out) begin
            first = i;
            break;
         end
      end
      checks++;
      if (first != 16 || seen_disp) begin
         errors++; $display("FAIL tmo_pulse: got at %0d disp=%0d want at 16 disp=0", first, seen_disp);
      end
      step();
      checks++;
      if (timeout_out !== 1'b0 || enc_valid_out !== 1'b1 || enc_letter_out !== 5'd12) begin
         errors++;
         $display("FAIL tmo_next: got tmo=%b v=%b l=%0d want 0 1 12",
                  timeout_out, enc_valid_out, enc_letter_out);
      end
      answer(core_fn(12), shown, dl, ds);
      checks++;
      if (!shown || dl !== core_fn(12) || drop_count_out !== 8'd0) begin
         errors++;
         $display("FAIL tmo_next_disp: got v=%0d l=%0d drops=%0d want 1 %0d 0",
                  shown, dl, drop_count_out, core_fn(12));
      end
   endtask

   task automatic test_reset_mid_wait();
      bit got, stray;
      logic [4:0] l;
      apply_reset();
      enc_ready_in = 1;
      ir_valid_in = 1; ir_letter_in = 13;
      step();
      ir_letter_in = 14;
      step();
      ir_valid_in = 0;
      wait_issue(got, l);
      step();
      step();
      #2 rst_in = 1'b0;
      #1;
      checks++;
      if (all_outs !== 48'h0) begin
         errors++; $display("FAIL rst_async: got %h want 0", all_outs);
      end
      step();
      rst_in = 1'b1;
      step();
      enc_valid_in = 1; enc_letter_in = 7;
      step();
      enc_valid_in = 0;
      checks++;
      if (disp_valid_out !== 1'b0) begin
         errors++; $display("FAIL rst_late_result: got %b want 0", disp_valid_out);
      end
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (enc_valid_out || busy_out) stray = 1;
      end
      checks++;
      if (stray || all_outs !== 48'h0) begin
         errors++; $display("FAIL rst_fifo_empty: got stray=%0d outs=%h want 0 0", stray, all_outs);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_cfg();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enigma_scheduler.md
Name: enigma_scheduler

Overview:
Sequences the shared Enigma cipher core between two letter requesters: the IR decoder (bursty) and the local switch/button letter entry. Also sequences rotor reconfiguration so it is never applied mid-letter. It buffers requests, arbitrates round-robin, issues one letter at a time to the core, and waits for the result. Each result is forwarded to the text display path with a source tag, and drops and timeouts are reported for the seven-segment debug view.

Parameters:
FIFO_DEPTH, 8, IR-side letter FIFO entries (power of two, ≥2)
TIMEOUT_CYCLES, 1024, max cycles waiting for a core result before abandoning the letter

Ports:
clk_in  in  1  system clock (100 MHz domain)
rst_in  in  1  reset, asynchronous, active-low
ir_valid_in  in  1  one-cycle strobe, IR letter available
ir_letter_in  in  5  IR letter, 0..25 valid
key_valid_in  in  1  one-cycle strobe, local letter available
key_letter_in  in  5  local letter, 0..25 valid
cfg_valid_in  in  1  one-cycle strobe, new rotor configuration
rotor_select_in  in  9  rotor selection
rotor_initial_in  in  15  rotor initial positions
enc_ready_in  in  1  core idle/ready
enc_valid_out  out  1  one-cycle letter strobe to core
enc_letter_out  out  5  letter to core
enc_rotor_valid_out  out  1  one-cycle config strobe to core
enc_rotor_select_out  out  9  config to core
enc_rotor_initial_out  out  15  config to core
enc_valid_in  in  1  core result strobe
enc_letter_in  in  5  core result
disp_valid_out  out  1  one-cycle result strobe to display
disp_letter_out  out  5  result letter
disp_src_out  out  1  0 = IR, 1 = local
drop_count_out  out  8  saturating dropped-letter count
timeout_out  out  1  one-cycle pulse on result timeout
busy_out  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (rst_in low, async): all outputs 0, FIFO empty, key slot empty, config-pending clear, round-robin pointer = IR, state IDLE, timeout counter 0.
- Intake (every cycle, any state):
  - ir_valid_in pushes into the FIFO; if the FIFO is full, the letter is dropped.
  - key_valid_in loads the 1-entry key slot; if the slot is occupied, the letter is dropped.
  - Letters > 25 from either source are dropped and never buffered.
  - Each drop increments drop_count_out, which saturates at 255.
  - Simultaneous IR and key strobes are both accepted independently.
- cfg_valid_in latches select/initial and sets config-pending in any state. A second request before service overwrites the first; only the latest is applied.
- FSM states: IDLE, CFG, CFG_WAIT, ISSUE, WAIT.
- IDLE:
  - Config-pending has priority: go to CFG. This does not require enc_ready_in.
  - Otherwise, if enc_ready_in and any letter is pending, grant round-robin and go to ISSUE:
    - If both sources are pending, grant the source ≠ the last-granted source.
    - If one source is pending, grant it.
  - The granted entry is popped in the grant cycle and latched with its source.
- CFG: enc_rotor_valid_out = 1 for exactly one cycle with the latched config; clear config-pending; go to CFG_WAIT.
- CFG_WAIT: stay at least one cycle; return to IDLE on the first cycle with enc_ready_in = 1.
- ISSUE: enc_valid_out = 1 for exactly one cycle with the latched letter; clear the timeout counter; go to WAIT.
- WAIT:
  - On enc_valid_in: next cycle, disp_valid_out = 1, disp_letter_out = enc_letter_in, disp_src_out = latched source; return to IDLE.
  - If TIMEOUT_CYCLES cycles elapse without a result: timeout_out pulses for one cycle, the letter is abandoned (not counted as a drop), return to IDLE.
  - enc_valid_in outside WAIT is ignored.
- A config request arriving during ISSUE/WAIT is serviced only after WAIT exits. There is never more than one letter outstanding.
- Latency: an ir_valid_in strobe at cycle 0 into an empty, idle system with enc_ready_in = 1 gives enc_valid_out at cycle 2. A result strobe at cycle k gives disp_valid_out at cycle k+1.
- Data outputs hold their last value between strobes.
- The FIFO pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle on a full FIFO: the pop happens first, the push succeeds, and there is no drop.
- Reset asserted mid-WAIT: all state clears immediately. A late enc_valid_in after reset release is ignored.

Test Plan:
- Single IR letter 7, core returns 19 after 5 cycles → enc_valid_out at cycle 2 with 7; disp_valid_out one cycle after the result with 19, src 0; busy_out falls afterward.
- IR letter 3 and key letter 4 on the same cycle, both pending → IR issued first, then key. Next test: IR 1,2 with key 9 → order 1, 9, 2.
- 10 IR strobes while the core holds enc_ready_in low → 8 buffered, drop_count_out = 2. Also key letter 30 → drop_count_out = 3, never issued.
- cfg_valid_in during WAIT → enc_rotor_valid_out is asserted only after disp_valid_out, and before the next queued letter. Two cfg strobes → only the second value is driven.
- Core never responds, TIMEOUT_CYCLES = 16 → timeout_out pulses 16 cycles after ISSUE; no disp_valid_out; the next queued letter is issued.
- rst_in low during WAIT, then an enc_valid_in after release → no disp_valid_out; all outputs 0; FIFO empty.
